// File: rtl/zmod_rx_align.sv
// Frame aligner for a multi-lane deserialised receive link.
// A one-hot framing lane selects the bit offset, a HUNT/VERIFY/LOCKED FSM
// commits it, and each data lane is realigned and checked for an
// incrementing pattern with per-lane saturating error counters.
module zmod_rx_align #(
    parameter int N        = 3,
    parameter int W        = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         sync_in,
    input  logic [N*W-1:0]       din,
    input  logic                 clr_count,
    output logic [N*W-1:0]       dout,
    output logic                 dout_valid,
    output logic                 locked,
    output logic [$clog2(W)-1:0] shift,
    output logic [N-1:0]         err_lane,
    output logic [N*16-1:0]      err_count
);

    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic [3:0]      cnt_inc;
    logic [SW-1:0]   shift_next;
    logic            sync_valid;
    logic [SW-1:0]   sync_off;
    logic            sync_match;
    logic [2*W-1:0]  hist [N];
    logic [N*W-1:0]  prev_dout;
    logic            prev_valid;
    logic [N-1:0]    mismatch;

    // Decode the framing word: only a one-hot word is a usable offset.
    always_comb begin
        sync_valid = (sync_in != '0) && ((sync_in & (sync_in - W'(1))) == '0);
        sync_off   = '0;
        for (int k = 0; k < W; k++) begin
            if (sync_in[k]) begin
                sync_off = SW'(k);
            end
        end
        sync_match = sync_valid && (sync_off == shift);
        cnt_inc    = cnt + 4'd1;
    end

    // Next-state logic for the alignment FSM; the offset only moves while hunting.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift;
        case (state)
            HUNT: begin
                if (sync_valid) begin
                    shift_next = sync_off;
                    if (LOCK_CNT == 1) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else begin
                        state_next = VERIFY;
                        cnt_next   = 4'd1;
                    end
                end
            end
            VERIFY: begin
                if (sync_match) begin
                    if (cnt_inc == 4'(LOCK_CNT)) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end
            end
            LOCKED: begin
                if (sync_match) begin
                    cnt_next = '0;
                end else if (cnt_inc == 4'(LOSS_CNT)) begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = HUNT;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state, counter and committed offset registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            cnt   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shift <= shift_next;
        end
    end

    assign locked = (state == LOCKED);

    // Per-lane two-word history and the realigned output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            dout       <= '0;
            dout_valid <= 1'b0;
            prev_dout  <= '0;
            prev_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hist[i]          <= {din[i*W +: W], hist[i][2*W-1:W]};
                dout[i*W +: W]   <= W'(hist[i] >> shift);
            end
            dout_valid <= locked;
            prev_dout  <= dout;
            prev_valid <= dout_valid;
        end
    end

    // Increment checker; the first valid word after lock only seeds prev_dout.
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < N; i++) begin
            mismatch[i] = dout_valid && prev_valid &&
                          (dout[i*W +: W] != (prev_dout[i*W +: W] + W'(1)));
        end
    end

    // Error pulses and saturating counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_lane  <= '0;
            err_count <= '0;
        end else begin
            err_lane <= mismatch;
            for (int i = 0; i < N; i++) begin
                if (clr_count) begin
                    err_count[i*16 +: 16] <= '0;
                end else if (mismatch[i] && (err_count[i*16 +: 16] != 16'hFFFF)) begin
                    err_count[i*16 +: 16] <= err_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zmod_rx_align.sv
// Directed testbench for zmod_rx_align with default parameters (N=3, W=8,
// LOCK_CNT=4, LOSS_CNT=2). Each lane carries an incrementing byte stream
// serialised at a chosen bit offset; expected outputs are written per step.
module tb_zmod_rx_align;

    localparam int N = 3;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sync_in;
    logic [N*W-1:0] din;
    logic          clr_count;
    logic [N*W-1:0] dout;
    logic          dout_valid;
    logic          locked;
    logic [2:0]    shift;
    logic [N-1:0]  err_lane;
    logic [N*16-1:0] err_count;

    int            tests = 0;
    int            fails = 0;
    int            j = 0;
    int            s_tx = 2;
    int            corrupt_idx = -100;
    int            stuck_from = 0;
    bit            stuck = 1'b0;
    logic [7:0]    stuck_val = 8'h00;

    zmod_rx_align #(.N(N), .W(W), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .din        (din),
        .clr_count  (clr_count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .shift      (shift),
        .err_lane   (err_lane),
        .err_count  (err_count)
    );

    // Free-running receive clock.
    always #5 clk = ~clk;

    // Word value carried on a lane at stream index idx.
    function automatic logic [7:0] aval(input int lane, input int idx);
        logic [7:0] v;
        v = 8'(lane * 64 + idx);
        if (lane == 1 && stuck && idx >= stuck_from) v = stuck_val;
        if (lane == 1 && idx == corrupt_idx) v = v ^ 8'h5A;
        return v;
    endfunction

    // Serialised word: the stream is rotated so word idx-1 lands at offset s_tx.
    function automatic logic [7:0] din_word(input int lane, input int idx);
        logic [15:0] pair;
        pair = {aval(lane, idx), aval(lane, idx - 1)};
        return 8'(pair >> (8 - s_tx));
    endfunction

    // Aligned output expected after the most recent edge (two cycles of latency).
    function automatic logic [N*W-1:0] exp_dout();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = aval(i, j - 3);
        return r;
    endfunction

    task automatic applyStimulus(input logic [7:0] s, input logic r, input logic c);
        rst       = r;
        sync_in   = s;
        clr_count = c;
        for (int i = 0; i < N; i++) din[i*W +: W] = din_word(i, j);
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("rst_locked", 64'(locked), 64'd0);
        checkOutput("rst_valid", 64'(dout_valid), 64'd0);
        checkOutput("rst_dout", 64'(dout), 64'd0);
        checkOutput("rst_shift", 64'(shift), 64'd0);
        checkOutput("rst_errlane", 64'(err_lane), 64'd0);
        checkOutput("rst_errcount", 64'(err_count), 64'd0);

        // Lock on offset 2 after four valid syncs
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(8'h04, 1'b0, 1'b0);
            checkOutput("lock_locked", 64'(locked), (k == 4) ? 64'd1 : 64'd0);
        end
        checkOutput("lock_shift", 64'(shift), 64'd2);
        checkOutput("lock_valid_lag", 64'(dout_valid), 64'd0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkOutput("lock_valid", 64'(dout_valid), 64'd1);
        checkOutput("lock_dout", 64'(dout), 64'(exp_dout()));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'h04, 1'b0, 1'b0);
            checkOutput("run_dout", 64'(dout), 64'(exp_dout()));
            checkOutput("run_errlane", 64'(err_lane), 64'd0);
        end
        checkOutput("run_errcount", 64'(err_count), 64'd0);

        // Single bad sync tolerated, two consecutive drop lock
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("glitch1_locked", 64'(locked), 64'd1);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkOutput("glitch2_locked", 64'(locked), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("loss1_locked", 64'(locked), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("loss2_locked", 64'(locked), 64'd0);
        checkOutput("loss2_valid", 64'(dout_valid), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("loss3_valid", 64'(dout_valid), 64'd0);
        checkOutput("loss_errcount", 64'(err_count), 64'd0);

        // VERIFY aborted by a different offset, then lock on offset 4
        applyStimulus(8'h04, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkOutput("abort_pre_locked", 64'(locked), 64'd0);
        s_tx = 4;
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("abort_locked", 64'(locked), 64'd0);
        checkOutput("abort_shift", 64'(shift), 64'd2);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(8'h10, 1'b0, 1'b0);
            checkOutput("relock4_locked", 64'(locked), (k == 4) ? 64'd1 : 64'd0);
        end
        checkOutput("relock4_shift", 64'(shift), 64'd4);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("relock4_valid", 64'(dout_valid), 64'd1);
        checkOutput("relock4_dout", 64'(dout), 64'(exp_dout()));
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("relock4_dout2", 64'(dout), 64'(exp_dout()));

        // One corrupted word on lane 1: bad word and recovery word both flagged
        corrupt_idx = j;
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr0_errlane", 64'(err_lane), 64'd0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr1_errlane", 64'(err_lane), 64'd0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr2_dout", 64'(dout), 64'(exp_dout()));
        checkOutput("corr2_errlane", 64'(err_lane), 64'd0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr3_errlane", 64'(err_lane), 64'h2);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr4_errlane", 64'(err_lane), 64'h2);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("corr5_errlane", 64'(err_lane), 64'd0);
        checkOutput("corr_errcount", 64'(err_count), 64'h0000_0002_0000);

        // Lane 1 stuck: one error per cycle up to 16'hFFFE, then saturation
        stuck_val  = aval(1, j - 1) + 8'h80;
        stuck_from = j;
        stuck      = 1'b1;
        for (int k = 0; k < 65535; k++) applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("sat_fffe", 64'(err_count), 64'h0000_FFFE_0000);
        for (int k = 0; k < 3; k++) applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("sat_ffff", 64'(err_count), 64'h0000_FFFF_0000);
        checkOutput("sat_errlane", 64'(err_lane), 64'h2);

        // Clear together with an ongoing error
        applyStimulus(8'h10, 1'b0, 1'b1);
        checkOutput("clr_errcount", 64'(err_count), 64'd0);
        checkOutput("clr_errlane", 64'(err_lane), 64'h2);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("postclr_errcount", 64'(err_count), 64'h0000_0001_0000);

        // Reset while locked, then relock with exactly four syncs
        checkOutput("prerst_locked", 64'(locked), 64'd1);
        stuck = 1'b0;
        applyStimulus(8'h10, 1'b1, 1'b0);
        checkOutput("midrst_locked", 64'(locked), 64'd0);
        checkOutput("midrst_valid", 64'(dout_valid), 64'd0);
        checkOutput("midrst_dout", 64'(dout), 64'd0);
        checkOutput("midrst_shift", 64'(shift), 64'd0);
        checkOutput("midrst_errlane", 64'(err_lane), 64'd0);
        checkOutput("midrst_errcount", 64'(err_count), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(8'h10, 1'b0, 1'b0);
            checkOutput("postrst_locked", 64'(locked), (k == 4) ? 64'd1 : 64'd0);
        end
        checkOutput("postrst_shift", 64'(shift), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zmod_rx_align.md
ZMOD_RX_ALIGN -- requirements
Module: zmod_rx_align

Interface
- REQ-001: The block SHALL have parameter N, default 3: number of data lanes, 1..8.
- REQ-002: The block SHALL have parameter W, default 8: deserialised word width per lane, 4 or 8.
- REQ-003: The block SHALL have parameter LOCK_CNT, default 4: consecutive matching sync words needed to lock, 1..15.
- REQ-004: The block SHALL have parameter LOSS_CNT, default 2: consecutive bad sync words needed to drop lock, 1..15.
- REQ-005: Port clk SHALL be an input, 1 bit: the single clock (rx divided clock domain); all logic is on the rising edge.
- REQ-006: Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
- REQ-007: Port sync_in SHALL be an input, W bits: deserialised word from the framing lane.
- REQ-008: Port din SHALL be an input, N*W bits: deserialised data words; lane i is din[i*W +: W].
- REQ-009: Port clr_count SHALL be an input, 1 bit: synchronous clear of the error counters.
- REQ-010: Port dout SHALL be an output, N*W bits: frame-aligned data words.
- REQ-011: Port dout_valid SHALL be an output, 1 bit: dout holds aligned data while locked.
- REQ-012: Port locked SHALL be an output, 1 bit: the alignment FSM is in LOCKED.
- REQ-013: Port shift SHALL be an output, $clog2(W) bits: the committed bit offset.
- REQ-014: Port err_lane SHALL be an output, N bits: one-cycle pulse per lane on an increment-check failure.
- REQ-015: Port err_count SHALL be an output, N*16 bits: per-lane saturating error count.

Function
- REQ-016: A sync word SHALL be valid only when it is exactly one-hot; set bit k gives candidate offset k. An all-zero or multi-hot word SHALL be invalid.
- REQ-017: On each cycle, each lane SHALL update a 2W-bit history register: hist_i <= {din_i, hist_i[2W-1:W]}.
- REQ-018: Aligned word SHALL be: dout_i <= hist_i >> shift, truncated to W bits and registered. Latency from din to dout SHALL be 2 clk cycles.
- REQ-019: The FSM SHALL have three states, HUNT, VERIFY and LOCKED, with a 4-bit counter cnt.
- REQ-020: HUNT, valid sync with offset k: shift <= k, cnt <= 1, go to VERIFY. Invalid sync: stay in HUNT.
- REQ-021: VERIFY, valid sync with offset equal to shift: cnt++. When cnt+1 reaches LOCK_CNT, go to LOCKED with cnt <= 0. An invalid sync or a different offset: go to HUNT with cnt <= 0.
- REQ-022: LOCK_CNT=1: HUNT SHALL go directly to LOCKED on the first valid sync.
- REQ-023: LOCKED, valid sync with matching offset: cnt <= 0. Otherwise cnt++. When cnt+1 reaches LOSS_CNT, go to HUNT.
- REQ-024: In LOCKED, shift SHALL NOT change; a differing offset counts as a miss.
- REQ-025: locked SHALL be high exactly while the state is LOCKED. dout_valid SHALL equal locked delayed 1 cycle, so it is aligned with dout.
- REQ-026: Checker, per lane, on a cycle where dout_valid is high and was high on the previous cycle: expect dout_i == (prev dout_i + 1) mod 2^W.
- REQ-027: The first dout_valid cycle after lock SHALL seed the checker and SHALL NOT be checked.
- REQ-028: On a check mismatch, err_lane[i] SHALL pulse high on the next cycle and err_count_i SHALL increment, saturating at 16'hFFFF.
- REQ-029: clr_count SHALL zero all counters on the next cycle. clr_count together with a mismatch on the same cycle: the clear wins (count = 0) and err_lane still pulses.
- REQ-030: Loss of lock SHALL clear dout_valid, suppress checking and not alter err_count.

Reset
- REQ-031: While rst is high, all of the following SHALL be 0: state (HUNT), cnt, shift, hist, dout, dout_valid, locked, err_lane, err_count.
- REQ-032: rst asserted mid-lock SHALL force HUNT and zero all outputs on the next edge. Relock SHALL need LOCK_CNT fresh valid syncs after rst drops.

Verification
- REQ-033: Test lock: sync_in = 8'h04 every cycle, each lane an incrementing byte pre-rotated by 2 bits -> locked rises after 4 valid syncs, shift = 2, dout counts +1 per cycle, err_count = 0.
- REQ-034: Test lock with glitch: in LOCKED, one sync word of 8'h00, then 8'h04 -> locked stays high; two consecutive 8'h00 -> locked falls and dout_valid falls 1 cycle later.
- REQ-035: Test VERIFY abort: 8'h04, 8'h04, 8'h10 -> return to HUNT; then 8'h10 ×4 -> locked with shift = 4.
- REQ-036: Test error counting: while locked, corrupt lane 1 for one word -> err_lane = 3'b010 for two pulses (bad word, then recovery word), err_count[1] = 2, other lanes 0.
- REQ-037: Test saturation and clear: force the count to 16'hFFFE, inject 3 errors -> 16'hFFFF held. Assert clr_count together with an error -> 0.
- REQ-038: Test reset mid-lock: assert rst for 1 cycle -> all outputs 0 next cycle; relock takes exactly LOCK_CNT valid syncs.
